rs232_avalon_uart: RTL and testbench

- Avalon-MM slave UART that the RSA wrapper polls. It sits between the board RS232 pins and the wrapper's avm_* master port.
- Exposes three 32-bit registers: RX data at byte address 0, TX data at 4, STATUS at 8.
- Serialises and deserialises 8N1 frames at a fixed baud rate with a one-byte buffer in each direction.

---
 rtl/rs232_pkg.sv | 23 ++
 rtl/uart_rx_deser.sv | 133 +++++++++++++
 rtl/rs232_avalon_uart.sv | 246 ++++++++++++++++++++++++
 tb/tb_rs232_avalon_uart.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared constants and types for the RS232 Avalon-MM UART.
// Contents: register byte addresses, STATUS bit positions, and the serial FSM
// state type used by both the transmitter and the receiver.
package rs232_pkg;

  localparam logic [4:0] RX_ADDR     = 5'd0;
  localparam logic [4:0] TX_ADDR     = 5'd4;
  localparam logic [4:0] STATUS_ADDR = 5'd8;

  localparam int unsigned RRDY_BIT = 7;
  localparam int unsigned TRDY_BIT = 6;
  localparam int unsigned TOE_BIT  = 4;
  localparam int unsigned ROE_BIT  = 3;
  localparam int unsigned FE_BIT   = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } serial_state_e;

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 receiver: input synchroniser plus a start/data/stop FSM.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   rx              raw serial input, idle high
//   rx_byte         last good byte (held until the next good frame)
//   byte_valid      one-cycle pulse when rx_byte is updated
//   frame_err       one-cycle pulse when a stop bit was sampled low
module uart_rx_deser
  import rs232_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  // Start bit is checked half a bit after the falling edge was seen.
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;

  serial_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            cnt_last;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign cnt_last = (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q <= rx_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // Requires a high-to-low transition, so a line stuck low after a
        // framing error is not mistaken for a new start bit.
        if (rx_prev_q && !rx_s) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte    = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/rs232_avalon_uart.sv
// Avalon-MM slave UART with one-byte RX and TX buffers, 8N1 framing.
// Registers: RX data (addr 0, read), TX data (addr 4, write), STATUS (addr 8,
// read; any write clears TOE/ROE/FE). Every bus access takes two cycles.
// Ports:
//   avm_clk, avm_rst_n         clock and asynchronous active-low reset
//   avs_address/read/write     Avalon-MM slave request
//   avs_writedata/readdata     32-bit data
//   avs_waitrequest            low only in the completing cycle of an access
//   rx_i, tx_o                 serial line, idle high
module rs232_avalon_uart
  import rs232_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  input  logic        rx_i,
  output logic        tx_o
);

  // Must be at least 4 for the half-bit start check to work.
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  // Bus handshake
  logic ack_q, ack_d;
  logic req, done, rd_done, wr_done;
  logic rx_rd, tx_wr, st_wr;

  // Register file
  logic [7:0] rx_buf_q, rx_buf_d;
  logic       rrdy_q, rrdy_d;
  logic       trdy_q, trdy_d;
  logic       toe_q, toe_d;
  logic       roe_q, roe_d;
  logic       fe_q, fe_d;
  logic [7:0] hold_q, hold_d;
  logic [31:0] status_word;

  // TX path
  serial_state_e   tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_line_q, tx_line_d;
  logic            tx_cnt_last;
  logic            load_tx;

  // RX path
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:8];

  uart_rx_deser #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk       (avm_clk),
    .rst_n     (avm_rst_n),
    .rx        (rx_i),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // ack_q marks the second (completing) cycle of an access.
  assign req     = avs_read | avs_write;
  assign ack_d   = req & ~ack_q;
  assign done    = req & ack_q;
  assign rd_done = done & avs_read;
  assign wr_done = done & avs_write & ~avs_read;
  assign rx_rd   = rd_done && (avs_address == RX_ADDR);
  assign tx_wr   = wr_done && (avs_address == TX_ADDR);
  assign st_wr   = wr_done && (avs_address == STATUS_ADDR);

  assign avs_waitrequest = ~ack_q;

  always_comb begin
    status_word           = '0;
    status_word[RRDY_BIT] = rrdy_q;
    status_word[TRDY_BIT] = trdy_q;
    status_word[TOE_BIT]  = toe_q;
    status_word[ROE_BIT]  = roe_q;
    status_word[FE_BIT]   = fe_q;
  end

  always_comb begin
    avs_readdata = '0;
    if (ack_q && avs_read) begin
      case (avs_address)
        RX_ADDR:     avs_readdata = {24'b0, rx_buf_q};
        STATUS_ADDR: avs_readdata = status_word;
        default:     avs_readdata = '0;
      endcase
    end
  end

  // RX-side flags. A byte landing in the same cycle as an RX data read
  // wins: RRDY stays set and it does not count as an overrun.
  always_comb begin
    rx_buf_d = rx_buf_q;
    rrdy_d   = rrdy_q;
    roe_d    = roe_q;
    fe_d     = fe_q;
    toe_d    = toe_q;
    if (rx_rd) begin
      rrdy_d = 1'b0;
    end
    if (st_wr) begin
      roe_d = 1'b0;
      fe_d  = 1'b0;
      toe_d = 1'b0;
    end
    if (byte_valid) begin
      rx_buf_d = rx_byte;
      rrdy_d   = 1'b1;
      if (rrdy_q && !rx_rd) begin
        roe_d = 1'b1;
      end
    end
    if (frame_err) begin
      fe_d = 1'b1;
    end
    if (tx_wr && !trdy_q) begin
      toe_d = 1'b1;
    end
  end

  assign tx_cnt_last = (tx_cnt_q == CntLast);
  // Holding register drains from IDLE or straight out of the stop bit so
  // consecutive bytes leave without an idle gap.
  assign load_tx = !trdy_q &&
                   ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && tx_cnt_last));

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    trdy_d     = trdy_q;
    hold_d     = hold_q;

    if (tx_wr && trdy_q) begin
      hold_d = avs_writedata[7:0];
      trdy_d = 1'b0;
    end

    unique case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
      end
      S_START: begin
        if (tx_cnt_last) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_last) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b1, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt_last) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    if (load_tx) begin
      tx_shift_d = hold_q;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_state_d = S_START;
      trdy_d     = 1'b1;
    end

    // Registered line level, derived from the next state to avoid glitches.
    case (tx_state_d)
      S_START: tx_line_d = 1'b0;
      S_DATA:  tx_line_d = tx_shift_d[0];
      default: tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      ack_q      <= 1'b0;
      rx_buf_q   <= '0;
      rrdy_q     <= 1'b0;
      trdy_q     <= 1'b1;
      toe_q      <= 1'b0;
      roe_q      <= 1'b0;
      fe_q       <= 1'b0;
      hold_q     <= '0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      ack_q      <= ack_d;
      rx_buf_q   <= rx_buf_d;
      rrdy_q     <= rrdy_d;
      trdy_q     <= trdy_d;
      toe_q      <= toe_d;
      roe_q      <= roe_d;
      fe_q       <= fe_d;
      hold_q     <= hold_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign tx_o = tx_line_q;

endmodule

// File: tb/tb_rs232_avalon_uart.sv
// Self-checking bench for rs232_avalon_uart at 10 clocks per bit.
// A frame-level model predicts the TX line waveform from the times bytes
// were accepted, and the register contents from bytes sent into rx_i.
module tb_rs232_avalon_uart;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned CPB    = 10;
  localparam int unsigned FRAME  = 10 * CPB;

  logic        avm_clk = 1'b0;
  logic        avm_rst_n = 1'b0;
  logic [4:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        rx_i = 1'b1;
  logic        tx_o;

  always #5 avm_clk = ~avm_clk;

  rs232_avalon_uart #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .SYNC_STAGES(2)
  ) dut (
    .avm_clk        (avm_clk),
    .avm_rst_n      (avm_rst_n),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_readdata   (avs_readdata),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_waitrequest(avs_waitrequest),
    .rx_i           (rx_i),
    .tx_o           (tx_o)
  );

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  bit exp_wait = 1'b1;
  bit mon_en = 1'b0;

  always @(posedge avm_clk) cyc <= cyc + 1;

  // Model state: scheduled TX frames (accept edge, start edge, data) and flags.
  int unsigned fr_w[$];
  int unsigned fr_s[$];
  logic [7:0]  fr_d[$];
  logic        m_rrdy, m_toe, m_roe, m_fe;
  logic [7:0]  m_rxbuf;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    fr_w.delete();
    fr_s.delete();
    fr_d.delete();
    m_rrdy = 1'b0;
    m_toe  = 1'b0;
    m_roe  = 1'b0;
    m_fe   = 1'b0;
    m_rxbuf = 8'h00;
  endtask

  // Holding register is full between its accept edge and the edge its frame starts.
  function automatic bit m_hold_full(input int unsigned c);
    if (fr_s.size() == 0) return 1'b0;
    return (fr_w[$] < c) && (c <= fr_s[$]);
  endfunction

  function automatic logic [31:0] m_status(input int unsigned c);
    return {24'b0, m_rrdy, !m_hold_full(c), 1'b0, m_toe, m_roe, m_fe, 2'b00};
  endfunction

  function automatic logic m_tx_line(input int unsigned n);
    int unsigned j;
    logic [7:0] d;
    foreach (fr_s[i]) begin
      if (n >= fr_s[i] && n < fr_s[i] + FRAME) begin
        j = (n - fr_s[i]) / CPB;
        d = fr_d[i];
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return d[j-1];
      end
    end
    return 1'b1;
  endfunction

  always @(negedge avm_clk) begin
    if (mon_en) begin
      check("tx_o", {31'b0, tx_o}, {31'b0, m_tx_line(cyc)});
      check("waitrequest", {31'b0, avs_waitrequest}, {31'b0, exp_wait});
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic bus(input logic [4:0] a, input bit rd, input bit wr, input logic [31:0] wd,
                     output logic [31:0] rdata, output int unsigned c);
    avs_address   = a;
    avs_read      = rd;
    avs_write     = wr;
    avs_writedata = wd;
    @(posedge avm_clk);
    #1 exp_wait = 1'b0;
    @(negedge avm_clk);
    rdata = avs_readdata;
    c = cyc + 1;
    @(posedge avm_clk);
    #1 exp_wait = 1'b1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic m_read(input logic [4:0] a, input bit also_wr, input string nm,
                        output logic [31:0] r);
    int unsigned c;
    logic [31:0] exp;
    bus(a, 1'b1, also_wr, $urandom, r, c);
    if (a == 5'd0) begin
      exp = {24'b0, m_rxbuf};
      m_rrdy = 1'b0;
    end else if (a == 5'd8) begin
      exp = m_status(c);
    end else begin
      exp = '0;
    end
    check(nm, r, exp);
  endtask

  task automatic m_write(input logic [4:0] a, input logic [31:0] d);
    int unsigned c;
    int unsigned s;
    logic [31:0] r;
    bus(a, 1'b0, 1'b1, d, r, c);
    if (a == 5'd4) begin
      if (m_hold_full(c)) begin
        m_toe = 1'b1;
      end else begin
        s = c + 1;
        if (fr_s.size() != 0 && fr_s[$] + FRAME > s) s = fr_s[$] + FRAME;
        fr_w.push_back(c);
        fr_s.push_back(s);
        fr_d.push_back(d[7:0]);
      end
    end else if (a == 5'd8) begin
      m_toe = 1'b0;
      m_roe = 1'b0;
      m_fe  = 1'b0;
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge avm_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    idle(CPB);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    drive_bit(1'b1);
    if (stop) begin
      if (m_rrdy) m_roe = 1'b1;
      m_rrdy  = 1'b1;
      m_rxbuf = b;
    end else begin
      m_fe = 1'b1;
    end
  endtask

  task automatic glitch();
    rx_i = 1'b0;
    idle(3);
    rx_i = 1'b1;
    idle(20);
  endtask

  task automatic pulse_reset();
    #2 avm_rst_n = 1'b0;
    mon_en = 1'b0;
    #1 check("tx_o_in_reset", {31'b0, tx_o}, 32'd1);
    check("wait_in_reset", {31'b0, avs_waitrequest}, 32'd1);
    m_reset();
    idle(3);
    avm_rst_n = 1'b1;
    mon_en = 1'b1;
    idle(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    m_reset();
    idle(3);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_wait", {31'b0, avs_waitrequest}, 32'd1);
    check("rst_tx", {31'b0, tx_o}, 32'd1);
    avm_rst_n = 1'b1;
    mon_en = 1'b1;
    idle(2);

    m_read(5'd8, 1'b0, "status_after_reset", r);
    check("status_after_reset_lit", r, 32'h40);

    send_rx(8'hA5, 1'b1);
    m_read(5'd8, 1'b0, "status_rx_a5", r);
    check("status_rx_a5_lit", r, 32'hC0);
    m_read(5'd0, 1'b0, "rxdata_a5", r);
    check("rxdata_a5_lit", r, 32'h0000_00A5);
    m_read(5'd8, 1'b0, "status_after_rd", r);
    check("status_after_rd_lit", r, 32'h40);

    m_write(5'd4, 32'h3C);
    m_read(5'd8, 1'b0, "trdy_after_load", r);
    check("trdy_after_load_lit", r, 32'h40);
    idle(110);

    m_write(5'd4, 32'h11);
    m_write(5'd4, 32'h22);
    m_write(5'd4, 32'h33);
    m_read(5'd8, 1'b0, "status_toe", r);
    check("status_toe_lit", r, 32'h10);
    m_write(5'd8, 32'h0);
    m_read(5'd8, 1'b0, "status_toe_clr", r);
    check("status_toe_clr_lit", r, 32'h00);
    idle(220);

    send_rx(8'h01, 1'b1);
    send_rx(8'h02, 1'b1);
    m_read(5'd8, 1'b0, "status_roe", r);
    check("status_roe_lit", r, 32'hC8);
    m_read(5'd0, 1'b0, "rxdata_02", r);
    check("rxdata_02_lit", r, 32'h02);
    send_rx(8'h55, 1'b0);
    m_read(5'd8, 1'b0, "status_fe", r);
    check("status_fe_lit", r, 32'h4C);
    m_write(5'd8, 32'hFFFF_FFFF);
    m_read(5'd8, 1'b0, "status_clr", r);
    check("status_clr_lit", r, 32'h40);

    glitch();
    m_read(5'd8, 1'b0, "status_glitch", r);
    check("status_glitch_lit", r, 32'h40);
    m_read(5'd0, 1'b0, "rxbuf_glitch", r);
    check("rxbuf_glitch_lit", r, 32'h02);

    m_read(5'd8, 1'b1, "rd_wr_is_read", r);
    m_read(5'd12, 1'b0, "unmapped_rd", r);
    check("unmapped_rd_lit", r, 32'h0);

    m_write(5'd4, 32'h96);
    idle(30);
    pulse_reset();
    m_read(5'd8, 1'b0, "status_post_reset", r);
    check("status_post_reset_lit", r, 32'h40);

    send_rx(8'($urandom), 1'b1);
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0, 1: send_rx(8'($urandom), ($urandom_range(0, 7) != 0));
        2: m_read(5'd0, 1'b0, "rnd_rxdata", r);
        3, 4: m_read(5'd8, 1'b0, "rnd_status", r);
        5, 6: m_write(5'd4, $urandom);
        7: m_write(5'd8, $urandom);
        8: begin
          if ($urandom_range(0, 1) == 0) m_read(5'(($urandom_range(9, 31))), 1'b0, "rnd_unmapped", r);
          else m_write(5'(($urandom_range(9, 31))), $urandom);
        end
        default: begin
          case ($urandom_range(0, 2))
            0: idle($urandom_range(1, 40));
            1: glitch();
            default: m_read(5'd8, 1'b1, "rnd_rd_wr", r);
          endcase
        end
      endcase
    end
    idle(2 * FRAME + 20);
    m_read(5'd8, 1'b0, "final_status", r);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
